// File: rtl/fir_pkg.sv
// Shared FIR definitions: sample width and the signed sample type.
package fir_pkg;

  localparam int unsigned FIR_DATA_W = 8;

  typedef logic signed [FIR_DATA_W-1:0] sample_t;

endpackage

// File: rtl/fir_decim_avg_if.sv
// Sample input, result output and status signals of the decimating averager.
interface fir_decim_avg_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FILL_W = 3
) ();

  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out_data;
  logic [FILL_W-1:0]        fill;
  logic                     overflow;

  // Producer/consumer side (testbench or upstream FIR plus downstream sink)
  modport master (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, fill, overflow
  );

  // Averager side
  modport slave (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, fill, overflow
  );

endinterface

// File: rtl/fir_result_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit fill counter.
// A push into a full FIFO is ignored unless a pop happens in the same cycle.
module fir_result_fifo
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic signed [DATA_W-1:0]     push_data,
  input  logic                         pop,
  output logic signed [DATA_W-1:0]     pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       fill
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]         wr_ptr;
  logic [PTR_W-1:0]         rd_ptr;
  logic [FILL_W-1:0]        count;
  logic signed [DATA_W-1:0] last;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == FILL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign fill    = count;
  // When empty, present the most recently popped value
  assign pop_data = empty ? last : mem[rd_ptr];

  // Storage, pointers, fill counter and last-popped register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last   <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        last   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/fir_decim_avg.sv
// Decimate the FIR output stream by 2**DECIM_LOG2, emitting the rounded block average
// into a small result FIFO. Results arriving at a full FIFO are dropped and flagged.
module fir_decim_avg
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W     = FIR_DATA_W,
  parameter int unsigned DECIM_LOG2 = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  fir_decim_avg_if.slave bus
);

  localparam int unsigned ACC_W = DATA_W + DECIM_LOG2;
  localparam int unsigned PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'((1 << DECIM_LOG2) - 1);

  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [PH_W-1:0]          phase;
  logic signed [DATA_W-1:0] res_next;
  logic signed [DATA_W-1:0] res;
  logic                     res_valid;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     overflow;

  assign sum = acc + ACC_W'(bus.in_data);

  if (DECIM_LOG2 == 0) begin : g_no_decim
    assign res_next = bus.in_data;
  end else begin : g_decim
    logic signed [ACC_W-1:0] rounded;
    // Sum plus half the divisor never exceeds the accumulator range
    always_comb begin
      rounded  = sum + ACC_W'(1 << (DECIM_LOG2 - 1));
      res_next = DATA_W'(rounded >>> DECIM_LOG2);
    end
  end

  // Accumulate samples, close a block on the last phase and register its result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      phase     <= '0;
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (bus.in_valid) begin
        if (phase == LAST_PHASE) begin
          res       <= res_next;
          res_valid <= 1'b1;
          acc       <= '0;
          phase     <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + 1'b1;
        end
      end
    end
  end

  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_valid = !empty;

  fir_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_valid),
    .push_data (res),
    .pop       (pop),
    .pop_data  (bus.out_data),
    .full      (full),
    .empty     (empty),
    .fill      (bus.fill)
  );

  // Sticky flag: a result met a full FIFO with no simultaneous pop
  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else if (res_valid && full && !pop) overflow <= 1'b1;
  end

  assign bus.overflow = overflow;

endmodule

// File: tb/tb_fir_decim_avg.sv
// Directed self-checking bench for fir_decim_avg (D = 4, FIFO depth 4).
module tb_fir_decim_avg;
  import fir_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fir_decim_avg_if #(.DATA_W(8), .FILL_W(3)) bus ();

  fir_decim_avg #(
    .DATA_W     (8),
    .DECIM_LOG2 (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then observed 1 ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input sample_t v);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic pop_one();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd0 || bus.fill !== 3'd0 ||
        bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid=%b data=%0d fill=%0d ovf=%b, required 0 0 0 0",
               bus.out_valid, bus.out_data, bus.fill, bus.overflow);
    end
  endtask

  task automatic test_first_block();
    for (int i = 0; i < 4; i++) send(8'sd10);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%b, required 0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'sd10 || bus.fill !== 3'd1) begin
      errors++;
      $display("FAIL first_block: valid=%b data=%0d fill=%0d, required 1 10 1",
               bus.out_valid, bus.out_data, bus.fill);
    end
    pop_one();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'sd10 || bus.fill !== 3'd0) begin
      errors++;
      $display("FAIL empty_holds_last: valid=%b data=%0d fill=%0d, required 0 10 0",
               bus.out_valid, bus.out_data, bus.fill);
    end
  endtask

  // Blocks of four samples each with hand-computed rounded averages
  task automatic test_rounding();
    sample_t blk [7][4] = '{
      '{8'sd1, 8'sd2, 8'sd3, 8'sd4},
      '{-8'sd1, -8'sd2, -8'sd3, -8'sd4},
      '{8'sd1, 8'sd1, 8'sd0, 8'sd0},
      '{8'sd127, 8'sd127, 8'sd127, 8'sd127},
      '{-8'sd128, -8'sd128, -8'sd128, -8'sd128},
      '{-8'sd1, -8'sd1, 8'sd0, 8'sd0},
      '{-8'sd3, 8'sd0, 8'sd0, 8'sd0}
    };
    sample_t exp_res [7] = '{8'sd3, -8'sd2, 8'sd1, 8'sd127, -8'sd128, 8'sd0, -8'sd1};
    for (int b = 0; b < 7; b++) begin
      for (int i = 0; i < 4; i++) send(blk[b][i]);
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_res[b]) begin
        errors++;
        $display("FAIL rounding[%0d]: valid=%b data=%0d, required 1 %0d",
                 b, bus.out_valid, bus.out_data, exp_res[b]);
      end
      pop_one();
    end
  endtask

  task automatic test_overflow();
    bus.out_ready = 1'b0;
    for (int k = 1; k <= 5; k++)
      for (int i = 0; i < 4; i++) send(sample_t'(k));
    tick();
    tick();
    checks++;
    if (bus.fill !== 3'd4 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: fill=%0d ovf=%b, required 4 1", bus.fill, bus.overflow);
    end
    bus.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sample_t'(k)) begin
        errors++;
        $display("FAIL drain[%0d]: valid=%b data=%0d, required 1 %0d",
                 k, bus.out_valid, bus.out_data, k);
      end
      tick();
    end
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.fill !== 3'd0 || bus.overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_end: valid=%b fill=%0d ovf=%b, required 0 0 1",
               bus.out_valid, bus.fill, bus.overflow);
    end
  endtask

  task automatic test_mid_block_reset();
    send(8'sd50);
    send(8'sd50);
    do_reset();
    checks++;
    if (bus.overflow !== 1'b0 || bus.fill !== 3'd0) begin
      errors++;
      $display("FAIL reset_clears: ovf=%b fill=%0d, required 0 0", bus.overflow, bus.fill);
    end
    for (int i = 0; i < 4; i++) send(8'sd8);
    tick();
    checks++;
    if (bus.out_data !== 8'sd8 || bus.fill !== 3'd1 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_block: data=%0d fill=%0d ovf=%b, required 8 1 0",
               bus.out_data, bus.fill, bus.overflow);
    end
    pop_one();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int k = 11; k <= 14; k++)
      for (int i = 0; i < 4; i++) send(sample_t'(k));
    tick();
    for (int i = 0; i < 4; i++) send(8'sd15);
    // Result of block 15 is pushed on this edge, together with a pop
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.fill !== 3'd4 || bus.overflow !== 1'b0 || bus.out_data !== 8'sd12) begin
      errors++;
      $display("FAIL full_push_pop: fill=%0d ovf=%b data=%0d, required 4 0 12",
               bus.fill, bus.overflow, bus.out_data);
    end
    bus.out_ready = 1'b1;
    for (int k = 12; k <= 15; k++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== sample_t'(k)) begin
        errors++;
        $display("FAIL b2b_drain[%0d]: valid=%b data=%0d, required 1 %0d",
                 k, bus.out_valid, bus.out_data, k);
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_single_push_pop();
    // fill==1, pop and push on the same edge: fill stays 1, head becomes the new result
    for (int i = 0; i < 4; i++) send(8'sd20);
    tick();
    for (int i = 0; i < 4; i++) send(8'sd30);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.fill !== 3'd1 || bus.out_data !== 8'sd30 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill1_push_pop: fill=%0d data=%0d ovf=%b, required 1 30 0",
               bus.fill, bus.out_data, bus.overflow);
    end
    pop_one();
  endtask

  task automatic test_gaps();
    // 3+5+7+9 = 24, (24+2)>>>2 = 6
    send(8'sd3);
    tick();
    send(8'sd5);
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL gap_no_timeout: out_valid=%b, required 0", bus.out_valid);
    end
    send(8'sd7);
    send(8'sd9);
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'sd6) begin
      errors++;
      $display("FAIL gaps: valid=%b data=%0d, required 1 6", bus.out_valid, bus.out_data);
    end
    pop_one();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_first_block();
    test_rounding();
    test_overflow();
    test_mid_block_reset();
    test_back_to_back();
    test_single_push_pop();
    test_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
